// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues word reads, buffers {addr,data} responses for decode.
// Latency: grant in N, rvalid in N+1 -> inst_valid_o in N+2. Requests stop once in-flight + buffered reaches FIFO_DEPTH.
// Optional INST_FETCH_MISALIGN_CHK_EN: a misaligned jump raises sticky misalign_o and halts fetch until reset.
module inst_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
`ifdef INST_FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

`ifdef INST_FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_RESET, S_RUN, S_FLUSH} state_t;
`endif

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [31:0]     last_addr_q, last_addr_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     mem_addr_q [FIFO_DEPTH];
    logic [31:0]     mem_data_q [FIFO_DEPTH];

    logic            jump_taken;
    logic            fire;
    logic            push;
    logic            pop;
    logic            credit;
    logic [CW:0]     inflight;
    logic [31:0]     jump_target;

    assign jump_target  = jump_addr_i & 32'hFFFF_FFFC;
    assign inflight     = {1'b0, outstanding_q} + {1'b0, count_q};
    assign credit       = inflight < (CW+1)'(FIFO_DEPTH);
    assign ibus_req_o   = (state_q == S_RUN) && credit && !jump_flag_i;
    assign ibus_addr_o  = pc_q;
    assign fire         = ibus_req_o && ibus_gnt_i;
    assign jump_taken   = jump_flag_i && ((state_q == S_RUN) || (state_q == S_FLUSH));
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? mem_data_q[rd_ptr_q] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? mem_addr_q[rd_ptr_q] : last_addr_q;

`ifdef INST_FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    assign misalign_o = misalign_q;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        last_addr_d   = last_addr_q;
        discard_d     = discard_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        push          = 1'b0;
        pop           = inst_valid_o && inst_ready_i && !jump_flag_i;
`ifdef INST_FETCH_MISALIGN_CHK_EN
        misalign_d    = misalign_q;
`endif
        outstanding_d = outstanding_q + CW'(fire) - CW'(ibus_rvalid_i);

        if (fire) pc_d = pc_q + 32'd4;
        if (inst_valid_o) last_addr_d = mem_addr_q[rd_ptr_q];

        // A response arriving in a jump cycle belongs to the old stream and is dropped.
        if (ibus_rvalid_i && !jump_taken) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end else begin
                push      = 1'b1;
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            S_RESET: state_d = S_RUN;
            S_FLUSH: if (discard_d == '0) state_d = S_RUN;
            default: state_d = state_q;
        endcase

        if (jump_taken) begin
            pc_d      = jump_target;
            resp_pc_d = jump_target;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            discard_d = outstanding_q - CW'(ibus_rvalid_i);
            state_d   = (discard_d != '0) ? S_FLUSH : S_RUN;
`ifdef INST_FETCH_MISALIGN_CHK_EN
            if (jump_addr_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_HALT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESET;
            pc_q          <= RESET_ADDR;
            resp_pc_q     <= RESET_ADDR;
            last_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
`ifdef INST_FETCH_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            last_addr_q   <= last_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
`ifdef INST_FETCH_MISALIGN_CHK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= resp_pc_q;
            mem_data_q[wr_ptr_q] <= ibus_rdata_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized bus/decode traffic checked against a
// transaction-level model of the fetch stream (address sequence, credit limit, stale-response drop).
`timescale 1ns/1ps
module tb_inst_fetch;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i = 1'b0;
    logic        ibus_rvalid_i = 1'b0;
    logic [31:0] ibus_rdata_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef INST_FETCH_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    inst_fetch #(.RESET_ADDR(32'h0), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o)
`ifdef INST_FETCH_MISALIGN_CHK_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: granted addresses wait in order until their due cycle.
    logic [31:0] bus_addr_q[$];
    int          bus_due_q[$];
    int          cyc = 0;

    // Fetch-stream model.
    logic [31:0] m_pc, m_resp_pc, m_last;
    logic [31:0] m_fifo[$];
    int          m_outs, m_discard, grants;
    bit          m_halt;

    // Stimulus knobs.
    int          gnt_pct, rdy_pct, dly_min, dly_max, jmp_pct, jmp_mode;
    logic [31:0] jmp_tgt, jmp_mask;

    task automatic do_reset();
        rst_n = 1'b0;
        jump_flag_i = 1'b0; jump_addr_i = '0; ibus_gnt_i = 1'b0;
        ibus_rvalid_i = 1'b0; ibus_rdata_i = '0; inst_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req", ibus_req_o, 1'b0);
        check("rst_addr", ibus_addr_o, 32'h0);
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, NOP);
        check("rst_inst_addr", inst_addr_o, 32'h0);
`ifdef INST_FETCH_MISALIGN_CHK_EN
        check("rst_misalign", misalign_o, 1'b0);
`endif
        bus_addr_q.delete(); bus_due_q.delete(); m_fifo.delete();
        m_pc = '0; m_resp_pc = '0; m_last = '0;
        m_outs = 0; m_discard = 0; m_halt = 0; grants = 0;
        rst_n = 1'b1;
        // Jump during the post-reset idle cycle must be ignored.
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0040;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bit rv, jmp, exp_req, exp_vld;
            logic [31:0] tgt;
            @(posedge clk);
            #1;
            cyc++;
            rv = (bus_addr_q.size() > 0) && (bus_due_q[0] <= cyc);
            ibus_rvalid_i = rv;
            ibus_rdata_i  = rv ? (bus_addr_q[0] ^ KEY) : $urandom;
            ibus_gnt_i    = ($urandom_range(99) < gnt_pct);
            inst_ready_i  = ($urandom_range(99) < rdy_pct);
            tgt = jmp_tgt;
            case (jmp_mode)
                1: begin jmp = ($urandom_range(99) < jmp_pct); tgt = $urandom & jmp_mask; end
                2: jmp = (m_outs == 2);
                3: jmp = rv && (m_fifo.size() > 0) && (m_discard == 0);
                4: jmp = 1'b1;
                default: jmp = 1'b0;
            endcase
            if (jmp && jmp_mode > 1) jmp_mode = 0;
            jump_flag_i = jmp;
            jump_addr_i = tgt;
            #1;
            exp_req = !m_halt && (m_discard == 0) && (m_outs + m_fifo.size() < DEPTH) && !jmp;
            exp_vld = !m_halt && (m_fifo.size() > 0);
            check("req", ibus_req_o, exp_req);
            if (exp_req) check("req_addr", ibus_addr_o, m_pc);
            check("inst_valid", inst_valid_o, exp_vld);
            if (exp_vld) begin
                check("inst_addr", inst_addr_o, m_fifo[0]);
                check("inst_data", inst_o, m_fifo[0] ^ KEY);
                m_last = m_fifo[0];
            end else begin
                check("idle_inst", inst_o, NOP);
                check("idle_addr", inst_addr_o, m_last);
            end
`ifdef INST_FETCH_MISALIGN_CHK_EN
            check("misalign", misalign_o, m_halt);
`endif
            if (exp_req && ibus_gnt_i) begin
                bus_addr_q.push_back(m_pc);
                bus_due_q.push_back(cyc + $urandom_range(dly_max, dly_min));
                m_pc += 32'd4;
                m_outs++;
                grants++;
            end
            if (rv) begin
                void'(bus_addr_q.pop_front());
                void'(bus_due_q.pop_front());
                m_outs--;
                if (!jmp) begin
                    if (m_discard > 0) m_discard--;
                    else begin
                        m_fifo.push_back(m_resp_pc);
                        m_resp_pc += 32'd4;
                    end
                end
            end
            if (exp_vld && inst_ready_i && !jmp) void'(m_fifo.pop_front());
            if (jmp && !m_halt) begin
                m_fifo.delete();
                m_discard = m_outs;
                m_pc      = tgt & 32'hFFFF_FFFC;
                m_resp_pc = m_pc;
`ifdef INST_FETCH_MISALIGN_CHK_EN
                if (tgt[1:0] != 2'b00) m_halt = 1;
`endif
            end
        end
    endtask

    task automatic knobs(input int g, input int r, input int dmin, input int dmax,
                         input int mode, input logic [31:0] tgt);
        gnt_pct = g; rdy_pct = r; dly_min = dmin; dly_max = dmax;
        jmp_mode = mode; jmp_tgt = tgt;
    endtask

    initial begin
        jmp_pct = 4;
`ifdef INST_FETCH_MISALIGN_CHK_EN
        jmp_mask = 32'hFFFF_FFFC;
`else
        jmp_mask = 32'hFFFF_FFFF;
`endif
        // Streaming at full rate.
        knobs(100, 100, 1, 1, 0, '0);
        do_reset();
        run_cycles(12);
        // Decode stalled: credit limits fetch to DEPTH grants.
        do_reset();
        knobs(100, 0, 1, 1, 0, '0);
        run_cycles(12);
        check("stall_grants", grants, DEPTH);
        knobs(100, 100, 1, 1, 0, '0);
        run_cycles(8);
        // Jump with two late responses in flight.
        do_reset();
        knobs(100, 100, 3, 3, 2, 32'h100);
        run_cycles(20);
        // Jump coinciding with rvalid and a ready decode.
        knobs(100, 100, 1, 1, 3, 32'h200);
        run_cycles(12);
        // Grant withheld for 5 cycles.
        knobs(0, 100, 1, 1, 0, '0);
        run_cycles(5);
        knobs(100, 100, 1, 1, 0, '0);
        run_cycles(6);
        // PC wrap past 2^32.
        knobs(100, 100, 1, 2, 4, 32'hFFFF_FFF8);
        run_cycles(12);
        // Randomized traffic, reset mid-stream between rounds.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            knobs(40 + 20 * r, 30 + 20 * r, 1, 1 + r, 1, '0);
            run_cycles(1500);
        end
`ifdef INST_FETCH_MISALIGN_CHK_EN
        do_reset();
        knobs(100, 100, 1, 2, 0, '0);
        run_cycles(6);
        knobs(100, 100, 1, 2, 4, 32'h102);
        run_cycles(15);
        do_reset();
        knobs(100, 100, 1, 1, 0, '0);
        run_cycles(6);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage. Owns the PC and issues word reads on the instruction bus.
- Buffers returned words with their addresses in a small FIFO.
- Presents inst_o and inst_addr_o to the decode stage with a valid/ready handshake.
- Producer side of the decoder's inst_i/inst_addr_i interface; redirects on jump_flag_i from execute.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value after reset.
FIFO_DEPTH, 2, instruction buffer entries; power of 2, >=2; also caps in-flight plus buffered requests.
NOP_INST, 32'h0000_0013, value on inst_o when no valid instruction (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
jump_flag_i  in  1  redirect request, single-cycle
jump_addr_i  in  32  redirect target
ibus_req_o  out  1  read request
ibus_addr_o  out  32  word address of request
ibus_gnt_i  in  1  request accepted this cycle
ibus_rvalid_i  in  1  read data valid; in order, >=1 cycle after grant
ibus_rdata_i  in  32  read data
inst_valid_o  out  1  inst_o/inst_addr_o valid
inst_ready_i  in  1  decode accepts this cycle
inst_o  out  32  instruction to decode
inst_addr_o  out  32  address of inst_o

Behaviour:
- Reset (async assert, sync use):
  - pc=RESET_ADDR, resp_pc=RESET_ADDR; FIFO empty; outstanding=0; discard=0; state=S_RESET.
  - Outputs: ibus_req_o=0, ibus_addr_o=RESET_ADDR, inst_valid_o=0, inst_o=NOP_INST, inst_addr_o=0.
- States:
  - S_RESET: one idle cycle after rst_n deasserts, then S_RUN.
  - S_RUN: normal fetch.
  - S_FLUSH: draining stale responses.
  - S_HALT: only with the optional feature.
- credit = (outstanding + fifo_count < FIFO_DEPTH).
- ibus_req_o = (state==S_RUN) && credit && !jump_flag_i. ibus_addr_o = pc.
- Bus handshake:
  - req/addr held stable until gnt. Withdrawal is permitted only in a jump cycle.
  - On req&&gnt: pc += 4 (wraps mod 2^32), outstanding += 1.
- Response:
  - ibus_rvalid_i decrements outstanding.
  - If discard>0: data dropped, discard -= 1.
  - Else: push {resp_pc, ibus_rdata_i} into the FIFO, resp_pc += 4.
- Output:
  - inst_valid_o = FIFO non-empty; inst_o/inst_addr_o = FIFO head.
  - When empty: inst_o = NOP_INST, inst_addr_o holds last value.
  - Pop on inst_valid_o && inst_ready_i && !jump_flag_i.
  - Push and pop in the same cycle are legal at any fill level. The credit rule guarantees no overflow.
- Jump (any state except S_RESET/S_HALT):
  - pc <= jump_addr_i, resp_pc <= jump_addr_i, FIFO cleared.
  - discard <= outstanding, minus 1 if rvalid is present that cycle; that response is itself dropped.
  - Next state: S_FLUSH if the resulting discard>0, else S_RUN.
  - Jump in S_FLUSH: same update; discard recomputed the same way.
  - Jump in S_RESET: ignored.
- S_FLUSH: no requests; return to S_RUN the cycle after discard reaches 0.
- Address bits [1:0] of jump_addr_i are forced to 0 (see Optional Feature).
- Reset mid-operation: everything returns to reset values immediately. Responses for pre-reset requests are a system error and outside scope.
- Latency: grant in cycle N with rvalid in N+1 gives inst_valid_o in N+2.

Optional Feature:
Macro INST_FETCH_MISALIGN_CHK_EN.
- Defined:
  - Extra output port misalign_o (1 bit, reset 0).
  - A jump with jump_addr_i[1:0]!=0 sets misalign_o=1 (sticky), clears the FIFO, and sets discard as for a normal jump.
  - State enters S_HALT: no requests issued, inst_valid_o=0. Stays there until reset.
- Undefined: no port, no S_HALT; jump_addr_i[1:0] forced to 00.

Test Plan:
1. Reset release, bus with gnt=1 always, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_0000, inst_ready_i=1 -> first req addr 0x0 one cycle after reset release; inst_o/inst_addr_o stream 0xA5A5_0000/0x0, 0xA5A5_0004/0x4, 0xA5A5_0008/0x8, one per cycle.
2. inst_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH(2) grants, then ibus_req_o=0; head stays 0x0. On ready=1, order 0x0, 0x4, 0x8 with no gaps or duplicates.
3. rvalid delayed 3 cycles, jump_flag_i=1 to 0x100 with 2 outstanding -> both late responses dropped; next inst_addr_o=0x100; no request issued until discard=0.
4. Jump to 0x200 in the same cycle as rvalid and inst_ready_i=1 with FIFO non-empty -> no pop observed; FIFO empty next cycle; first delivered inst_addr_o=0x200.
5. gnt held low 5 cycles -> ibus_req_o=1 and ibus_addr_o constant for all 5 cycles; pc advances by exactly 4 on grant.
6. With INST_FETCH_MISALIGN_CHK_EN defined, jump to 0x102 -> misalign_o=1 next cycle; ibus_req_o and inst_valid_o stay 0 until rst_n low; both clear on reset.
